// File: rtl/tmr_pkg.sv
// Shared types for the triplicated, scrubbed register file.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package tmr_pkg;

    // Number of stored copies per word.
    localparam int COPIES = 3;

    // Selects one of the copies; value 3 names no copy.
    typedef logic [1:0] copy_idx_t;

    // Scrubber walks IDLE -> CHECK -> (FIX) -> NEXT -> IDLE, one address per walk.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIX   = 2'd2,
        NEXT  = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/tmr_vote_unit.sv
// Bitwise 2-of-3 majority voter with a copy-disagreement flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cp[COPIES] in (the three copies), vote out (majority word),
//        mismatch out (at least one copy differs from another).
module tmr_vote_unit
    import tmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cp [COPIES],
    output logic [WIDTH-1:0] vote,
    output logic             mismatch
);

    always_comb begin
        vote     = (cp[0] & cp[1]) | (cp[0] & cp[2]) | (cp[1] & cp[2]);
        // If copy 0 matches both others, all three are equal.
        mismatch = (cp[0] != cp[1]) || (cp[0] != cp[2]);
    end

endmodule

// File: rtl/tmr_scrub_regfile.sv
// Triplicated register file with majority-voted reads and a background scrubber
// that rewrites disagreeing copies with the voted word.
// Latency: read data one cycle after rdEn; writes land at the clock edge.
// Backpressure: none; the scrubber never stalls user reads or writes.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   wrEn/wrAddr/wrData       write strobe, address, data (stored to all copies)
//   rdEn/rdAddr              read strobe, address
//   rdData/rdValid/rdErr     voted data, valid, copies-disagreed flag
//   scrubBusy                scrubber not in IDLE
//   corrCnt                  saturating count of scrubber corrections
//   fatalErr                 sticky: a scrubbed word had no two identical copies
// Build option TMR_INJECT_EN adds injEn/injCopy/injAddr/injBit, which invert a
// single bit of one copy of one word for fault testing.
module tmr_scrub_regfile
    import tmr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
`ifdef TMR_INJECT_EN
    input  logic                     injEn,
    input  copy_idx_t                injCopy,
    input  logic [$clog2(DEPTH)-1:0] injAddr,
    input  logic [$clog2(WIDTH)-1:0] injBit,
`endif
    output logic [WIDTH-1:0]         rdData,
    output logic                     rdValid,
    output logic                     rdErr,
    output logic                     scrubBusy,
    output logic [CNT_WIDTH-1:0]     corrCnt,
    output logic                     fatalErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

    // Three independent copies; kept separate so they are not merged into one.
    (* keep *) logic [WIDTH-1:0] mem0_q [DEPTH];
    (* keep *) logic [WIDTH-1:0] mem1_q [DEPTH];
    (* keep *) logic [WIDTH-1:0] mem2_q [DEPTH];
    logic [WIDTH-1:0] mem0_d [DEPTH];
    logic [WIDTH-1:0] mem1_d [DEPTH];
    logic [WIDTH-1:0] mem2_d [DEPTH];

    scrub_state_t          state_q, state_d;
    logic [PW-1:0]         period_q, period_d;
    logic [AW-1:0]         scrub_addr_q, scrub_addr_d;
    logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
    logic                  fatal_q, fatal_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                  rd_err_q, rd_err_d;

    logic [WIDTH-1:0] rd_cp [COPIES];
    logic [WIDTH-1:0] sc_cp [COPIES];
    logic [WIDTH-1:0] rd_vote, sc_vote;
    logic             rd_mis, sc_mis, sc_all_differ;
    logic             user_hit;
    logic             scrub_wb;

    // ---------------- voting ----------------
    always_comb begin
        rd_cp[0] = mem0_q[rdAddr];
        rd_cp[1] = mem1_q[rdAddr];
        rd_cp[2] = mem2_q[rdAddr];
        sc_cp[0] = mem0_q[scrub_addr_q];
        sc_cp[1] = mem1_q[scrub_addr_q];
        sc_cp[2] = mem2_q[scrub_addr_q];
    end

    tmr_vote_unit #(.WIDTH(WIDTH)) u_rd_vote (
        .cp       (rd_cp),
        .vote     (rd_vote),
        .mismatch (rd_mis)
    );

    tmr_vote_unit #(.WIDTH(WIDTH)) u_sc_vote (
        .cp       (sc_cp),
        .vote     (sc_vote),
        .mismatch (sc_mis)
    );

    // No pair of copies agrees: the vote is a guess, not a correction.
    assign sc_all_differ = (sc_cp[0] != sc_cp[1]) && (sc_cp[0] != sc_cp[2])
                        && (sc_cp[1] != sc_cp[2]);

    // A user write to the word under scrub supersedes the scrubber's view of it.
    assign user_hit = wrEn && (wrAddr == scrub_addr_q);

    // ---------------- scrub FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            period_q     <= '0;
            scrub_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            scrub_addr_q <= scrub_addr_d;
        end
    end

    // ---------------- scrub FSM: next state ----------------
    always_comb begin
        state_d      = state_q;
        period_d     = '0;
        scrub_addr_d = scrub_addr_q;
        case (state_q)
            IDLE: begin
                if (period_q == PW'(SCRUB_PERIOD - 1)) begin
                    state_d = CHECK;
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
            CHECK: begin
                // A concurrent user write refreshes all copies anyway.
                state_d = (sc_mis && !user_hit) ? FIX : NEXT;
            end
            FIX: begin
                state_d = NEXT;
            end
            NEXT: begin
                // DEPTH is a power of two, so the increment wraps to 0.
                scrub_addr_d = scrub_addr_q + AW'(1);
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- scrub FSM: outputs ----------------
    always_comb begin
        scrubBusy  = (state_q != IDLE);
        scrub_wb   = (state_q == FIX) && !user_hit;
        corr_cnt_d = corr_cnt_q;
        fatal_d    = fatal_q;
        if (scrub_wb && (corr_cnt_q != {CNT_WIDTH{1'b1}})) begin
            corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
        end
        // The word was found unrecoverable even if a user write then replaced it.
        if ((state_q == FIX) && sc_all_differ) begin
            fatal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt_q <= '0;
            fatal_q    <= 1'b0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
            fatal_q    <= fatal_d;
        end
    end

    // ---------------- storage update ----------------
    // Priority, lowest to highest: scrub writeback, user write, injection flip.
    // The scrub writeback already stands down on a user-write collision.
`ifdef TMR_INJECT_EN
    logic [WIDTH-1:0] inj_mask;
    assign inj_mask = WIDTH'(1) << injBit;
`endif

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        mem2_d = mem2_q;
        if (scrub_wb) begin
            mem0_d[scrub_addr_q] = sc_vote;
            mem1_d[scrub_addr_q] = sc_vote;
            mem2_d[scrub_addr_q] = sc_vote;
        end
        if (wrEn) begin
            mem0_d[wrAddr] = wrData;
            mem1_d[wrAddr] = wrData;
            mem2_d[wrAddr] = wrData;
        end
`ifdef TMR_INJECT_EN
        if (injEn) begin
            case (injCopy)
                2'd0:    mem0_d[injAddr] = mem0_d[injAddr] ^ inj_mask;
                2'd1:    mem1_d[injAddr] = mem1_d[injAddr] ^ inj_mask;
                2'd2:    mem2_d[injAddr] = mem2_d[injAddr] ^ inj_mask;
                default: ; // copy index 3 selects nothing
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem0_q[i] <= '0;
                mem1_q[i] <= '0;
                mem2_q[i] <= '0;
            end
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            mem2_q <= mem2_d;
        end
    end

    // ---------------- read port ----------------
    // The vote is taken from the pre-edge copies, so a same-cycle write to the
    // read address is not visible until the next read.
    always_comb begin
        rd_valid_d = rdEn;
        rd_data_d  = rdEn ? rd_vote : rd_data_q;
        rd_err_d   = rdEn ? rd_mis  : rd_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rdValid  = rd_valid_q;
    assign rdData   = rd_data_q;
    assign rdErr    = rd_err_q;
    assign corrCnt  = corr_cnt_q;
    assign fatalErr = fatal_q;

endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Randomized bench for tmr_scrub_regfile against a cycle-timeline reference model.
// Latency: checks every cycle; read results expected one cycle after the strobe.
// Backpressure: the DUT has none, so stimulus is applied every cycle.
module tb_tmr_scrub_regfile;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int P     = 5;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int WAIT_LIMIT = 4 * DEPTH * (P + 3) + 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       inj_en;
    logic [1:0] inj_copy;
    logic [2:0] inj_addr;
    logic [2:0] inj_bit;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_err;
    logic       scrub_busy;
    logic [2:0] corr_cnt;
    logic       fatal_err;

    always #5 clk = ~clk;

    tmr_scrub_regfile #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_PERIOD(P), .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wr_en),
        .wrAddr   (wr_addr),
        .wrData   (wr_data),
        .rdEn     (rd_en),
        .rdAddr   (rd_addr),
`ifdef TMR_INJECT_EN
        .injEn    (inj_en),
        .injCopy  (inj_copy),
        .injAddr  (inj_addr),
        .injBit   (inj_bit),
`endif
        .rdData   (rd_data),
        .rdValid  (rd_valid),
        .rdErr    (rd_err),
        .scrubBusy(scrub_busy),
        .corrCnt  (corr_cnt),
        .fatalErr (fatal_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory as three plain copy arrays; the scrubber as a timeline of the
    // cycle numbers at which the next check, fix and advance happen.
    int cp [3][DEPTH];
    int cyc, check_at, fix_at, next_at, sc_addr, m_cnt, m_wb;
    bit m_fatal, e_valid, e_err;
    int e_data;

    function automatic int mvote(int a, int b, int c);
        int r = 0;
        for (int k = 0; k < WIDTH; k++) begin
            int ones = ((a >> k) & 1) + ((b >> k) & 1) + ((c >> k) & 1);
            if (ones >= 2) r |= (1 << k);
        end
        return r;
    endfunction

    function automatic bit agree(int a);
        return (cp[0][a] == cp[1][a]) && (cp[1][a] == cp[2][a]);
    endfunction

    function automatic bit no_pair(int a);
        return (cp[0][a] != cp[1][a]) && (cp[0][a] != cp[2][a]) && (cp[1][a] != cp[2][a]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < DEPTH; a++) cp[c][a] = 0;
        cyc = 0; check_at = P; fix_at = -1; next_at = -1;
        sc_addr = 0; m_cnt = 0; m_wb = 0; m_fatal = 0;
        e_valid = 0; e_data = 0; e_err = 0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit hit;
        int v;
        hit = wr_en && (int'(wr_addr) == sc_addr);
        if (rd_en) begin
            e_data = mvote(cp[0][rd_addr], cp[1][rd_addr], cp[2][rd_addr]);
            e_err  = !agree(int'(rd_addr));
        end
        e_valid = rd_en;
        if (cyc == check_at) begin
            if (!agree(sc_addr) && !hit) fix_at = cyc + 1;
            else next_at = cyc + 1;
        end else if (cyc == fix_at) begin
            v = mvote(cp[0][sc_addr], cp[1][sc_addr], cp[2][sc_addr]);
            if (no_pair(sc_addr)) m_fatal = 1;
            if (!hit) begin
                for (int c = 0; c < 3; c++) cp[c][sc_addr] = v;
                if (m_cnt < CMAX) m_cnt++;
                m_wb++;
            end
            next_at = cyc + 1;
        end else if (cyc == next_at) begin
            sc_addr  = (sc_addr + 1) % DEPTH;
            check_at = cyc + 1 + P;
        end
        if (wr_en)
            for (int c = 0; c < 3; c++) cp[c][wr_addr] = int'(wr_data);
`ifdef TMR_INJECT_EN
        if (inj_en && inj_copy != 2'd3)
            cp[inj_copy][inj_addr] = cp[inj_copy][inj_addr] ^ (1 << inj_bit);
`endif
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
        inj_en = 0; inj_copy = 0; inj_addr = 0; inj_bit = 0;
    endtask

    // Entered at posedge+1 with inputs set; checks the cycle, then steps.
    task automatic tick();
        @(negedge clk);
        check_eq("scrubBusy", 32'(scrub_busy), 32'(cyc >= check_at));
        check_eq("corrCnt", 32'(corr_cnt), 32'(m_cnt));
        check_eq("fatalErr", 32'(fatal_err), 32'(m_fatal));
        check_eq("rdValid", 32'(rd_valid), 32'(e_valid));
        if (e_valid) begin
            check_eq("rdData", 32'(rd_data), 32'(e_data));
            check_eq("rdErr", 32'(rd_err), 32'(e_err));
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        idle(); wr_en = 1; wr_addr = 3'(a); wr_data = 8'(d); tick(); idle();
    endtask

    task automatic do_read(input int a);
        idle(); rd_en = 1; rd_addr = 3'(a); tick(); idle();
    endtask

`ifdef TMR_INJECT_EN
    task automatic do_inject(input int c, input int a, input int b);
        idle(); inj_en = 1; inj_copy = 2'(c); inj_addr = 3'(a); inj_bit = 3'(b); tick(); idle();
    endtask

    // Idle until the scrubber has just advanced past address a.
    task automatic wait_past(input int a, input string tag);
        bit done = 0;
        idle();
        for (int i = 0; i < WAIT_LIMIT && !done; i++) begin
            if (cyc == next_at && sc_addr == a) done = 1;
            else tick();
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask
`endif

    task automatic do_reset();
        idle(); rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cnt_save;
        bit done;
        idle();
        rst = 1;
        @(posedge clk); #1;
        do_reset();
        check_eq("rst_rdValid", 32'(rd_valid), 32'd0);
        check_eq("rst_rdData", 32'(rd_data), 32'd0);
        check_eq("rst_rdErr", 32'(rd_err), 32'd0);
        check_eq("rst_busy", 32'(scrub_busy), 32'd0);
        check_eq("rst_corrCnt", 32'(corr_cnt), 32'd0);
        check_eq("rst_fatal", 32'(fatal_err), 32'd0);

        // Basic write then read.
        do_write(3, 8'hA5);
        do_read(3);
        check_eq("t1_rdValid", 32'(rd_valid), 32'd1);
        check_eq("t1_rdData", 32'(rd_data), 32'hA5);
        check_eq("t1_rdErr", 32'(rd_err), 32'd0);

        // Read-during-write returns the old word; the write still lands.
        idle(); wr_en = 1; wr_addr = 3; wr_data = 8'h5A; rd_en = 1; rd_addr = 3;
        tick(); idle();
        check_eq("rdw_old", 32'(rd_data), 32'hA5);
        do_read(3);
        check_eq("rdw_new", 32'(rd_data), 32'h5A);

`ifdef TMR_INJECT_EN
        // Single upset: voted read hides it, scrubber repairs it.
        do_write(3, 8'hA5);
        wait_past(3, "t2_wait_pos");
        do_inject(1, 3, 0);
        do_read(3);
        check_eq("t2_rdData", 32'(rd_data), 32'hA5);
        check_eq("t2_rdErr", 32'(rd_err), 32'd1);
        wait_past(3, "t2_wait_fix");
        do_read(3);
        check_eq("t2_rdErr_after", 32'(rd_err), 32'd0);
        check_eq("t2_corrCnt", 32'(corr_cnt), 32'd1);

        // Three different upsets: no pair agrees, fatal flag latches.
        do_write(5, 8'h00);
        wait_past(5, "t3_wait_pos");
        do_inject(0, 5, 0);
        do_inject(1, 5, 1);
        do_inject(2, 5, 2);
        wait_past(5, "t3_wait_fix");
        check_eq("t3_fatal", 32'(fatal_err), 32'd1);
        check_eq("t3_corrCnt", 32'(corr_cnt), 32'd2);
        do_read(5);
        check_eq("t3_rdData", 32'(rd_data), 32'h00);
        check_eq("t3_rdErr", 32'(rd_err), 32'd0);

        // User write in the FIX cycle wins over the scrub writeback.
        do_write(2, 8'h11);
        wait_past(2, "t5_wait_pos");
        do_inject(0, 2, 4);
        done = 0;
        for (int i = 0; i < WAIT_LIMIT && !done; i++) begin
            if (cyc == fix_at && sc_addr == 2) done = 1;
            else tick();
        end
        check_eq("t5_wait_fix", 32'(done), 32'd1);
        cnt_save = m_cnt;
        do_write(2, 8'h3C);
        do_read(2);
        check_eq("t5_rdData", 32'(rd_data), 32'h3C);
        check_eq("t5_rdErr", 32'(rd_err), 32'd0);
        check_eq("t5_corrCnt", 32'(corr_cnt), 32'(cnt_save));

        // Saturation: keep corrupting until the counter is full, then once more.
        done = 0;
        for (int i = 0; i < 20 * WAIT_LIMIT && !done; i++) begin
            idle();
            if (i % 4 == 0) begin
                inj_en = 1; inj_copy = 2'(i % 3);
                inj_addr = 3'($urandom_range(0, DEPTH - 1));
                inj_bit = 3'($urandom_range(0, WIDTH - 1));
            end
            tick();
            if (m_cnt == CMAX) done = 1;
        end
        cnt_save = m_wb;
        done = 0;
        for (int i = 0; i < 20 * WAIT_LIMIT && !done; i++) begin
            idle();
            if (i % 4 == 0) begin
                inj_en = 1; inj_copy = 2'(i % 3);
                inj_addr = 3'($urandom_range(0, DEPTH - 1)); inj_bit = 0;
            end
            tick();
            if (m_wb > cnt_save) done = 1;
        end
        idle();
        check_eq("sat_reached", 32'(done), 32'd1);
        check_eq("sat_corrCnt", 32'(corr_cnt), 32'(CMAX));
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            idle();
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, DEPTH - 1));
            wr_data = 8'($urandom_range(0, 255));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 3'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) begin
                inj_en   = 1;
                inj_copy = 2'($urandom_range(0, 3));
                inj_addr = 3'($urandom_range(0, DEPTH - 1));
                inj_bit  = 3'($urandom_range(0, WIDTH - 1));
            end
            tick();
        end
        idle();

        // Reset while the scrubber is in CHECK.
        do_write(6, 8'h77);
        done = 0;
        for (int i = 0; i < WAIT_LIMIT && !done; i++) begin
            if (cyc == check_at) done = 1;
            else do_read(6);
        end
        check_eq("mid_wait_check", 32'(done), 32'd1);
        idle(); rst = 1;
        @(posedge clk); #1;
        check_eq("mid_rdValid", 32'(rd_valid), 32'd0);
        check_eq("mid_rdData", 32'(rd_data), 32'd0);
        check_eq("mid_rdErr", 32'(rd_err), 32'd0);
        check_eq("mid_busy", 32'(scrub_busy), 32'd0);
        check_eq("mid_corrCnt", 32'(corr_cnt), 32'd0);
        check_eq("mid_fatal", 32'(fatal_err), 32'd0);
        rst = 0;
        model_reset();
        do_read(6);
        check_eq("mid_mem_cleared", 32'(rd_data), 32'd0);
        for (int i = 0; i < 3 * (P + 3); i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
